// File: rtl/riscv_vec_pkg.sv
`timescale 1ns/1ps
// riscv_vec_pkg: shared constants and FSM state type for the vector datapath.
package riscv_vec_pkg;

  localparam int unsigned VLMAX  = 8;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned VEC_W  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } vld_state_e;

endpackage

// File: rtl/riscv_core_vec_lane_buf.sv
`timescale 1ns/1ps
// riscv_core_vec_lane_buf: VLMAX x LANE_W lane buffer with indexed write,
// synchronous clear and a zero-mask for lanes at or above n.
module riscv_core_vec_lane_buf #(
  parameter int unsigned VLMAX  = 8,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_wr_en,
  input  logic [IDX_W-1:0]          i_wr_idx,
  input  logic [LANE_W-1:0]         i_wr_data,
  input  logic                      i_clr,
  input  logic [3:0]                i_n,
  output logic [VLMAX*LANE_W-1:0]   o_data
);

  logic [LANE_W-1:0] r_lane [VLMAX];

  // Lane storage: cleared on reset or clear, otherwise one indexed write per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < VLMAX; i++) r_lane[i] <= '0;
    end else if (i_clr) begin
      for (int unsigned i = 0; i < VLMAX; i++) r_lane[i] <= '0;
    end else if (i_wr_en) begin
      r_lane[i_wr_idx] <= i_wr_data;
    end
  end

  // Pack lanes into the vector, forcing lanes at or above n to zero.
  always_comb begin
    o_data = '0;
    for (int unsigned i = 0; i < VLMAX; i++) begin
      if (i < 32'(i_n)) o_data[i*LANE_W +: LANE_W] = r_lane[i];
    end
  end

endmodule

// File: rtl/riscv_core_vec_load_unit.sv
`timescale 1ns/1ps
// riscv_core_vec_load_unit: accepts one vector-load command, issues up to
// VLMAX word reads, gathers in-order responses and commits one 256-bit write.
// Build option: VECLD_STRIDE_EN latches cmd_stride; otherwise unit stride (4).
module riscv_core_vec_load_unit #(
  parameter int unsigned VLMAX  = riscv_vec_pkg::VLMAX,
  parameter int unsigned LANE_W = riscv_vec_pkg::LANE_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_val,
  output logic                     cmd_rdy,
  input  logic [4:0]               cmd_vd,
  input  logic [31:0]              cmd_base,
  input  logic [31:0]              cmd_stride,
  input  logic [3:0]               vl,
  output logic                     memreq_val,
  input  logic                     memreq_rdy,
  output logic [31:0]              memreq_addr,
  input  logic                     memresp_val,
  input  logic [31:0]              memresp_data,
  output logic                     wen_p,
  output logic [4:0]               waddr_p,
  output logic [VLMAX*LANE_W-1:0]  wdata_p,
  output logic                     busy
);
  import riscv_vec_pkg::*;

  localparam int unsigned IDX_W = (VLMAX > 1) ? $clog2(VLMAX) : 1;

  vld_state_e   r_state;
  logic [3:0]   r_ic;
  logic [3:0]   r_rc;
  logic [3:0]   r_n;
  logic [4:0]   r_vd;
  logic [31:0]  r_addr;
  logic [3:0]   w_n;
  logic [31:0]  w_stride;
  logic         w_req_fire;
  logic         w_resp_take;
  logic [VLMAX*LANE_W-1:0] w_lanes;

`ifdef VECLD_STRIDE_EN
  logic [31:0]  r_stride;
  assign w_stride = r_stride;
`else
  logic         w_unused_stride;
  assign w_stride        = 32'd4;
  assign w_unused_stride = ^cmd_stride;
`endif

  assign w_n         = ({28'd0, vl} > VLMAX) ? 4'(VLMAX) : vl;
  assign w_req_fire  = memreq_val && memreq_rdy;
  assign w_resp_take = (r_state == ISSUE) && memresp_val && (r_rc < r_n);

  assign cmd_rdy     = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign memreq_val  = (r_state == ISSUE) && (r_ic < r_n);
  assign memreq_addr = memreq_val ? r_addr : '0;
  assign wen_p       = (r_state == WRITE);
  assign waddr_p     = wen_p ? r_vd : '0;
  assign wdata_p     = wen_p ? w_lanes : '0;

  // Command FSM with issue/receive counters; r_addr accumulates the stride
  // per accepted request, equivalent to base + ic*stride mod 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_ic     <= '0;
      r_rc     <= '0;
      r_n      <= '0;
      r_vd     <= '0;
      r_addr   <= '0;
`ifdef VECLD_STRIDE_EN
      r_stride <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_val) begin
            r_vd     <= cmd_vd;
            r_addr   <= cmd_base;
            r_n      <= w_n;
`ifdef VECLD_STRIDE_EN
            r_stride <= cmd_stride;
`endif
            r_state  <= (w_n == 4'd0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (w_req_fire) begin
            r_ic   <= r_ic + 4'd1;
            r_addr <= r_addr + w_stride;
          end
          if (w_resp_take) begin
            r_rc <= r_rc + 4'd1;
            if ((r_rc + 4'd1) == r_n) r_state <= WRITE;
          end
        end
        WRITE: r_state <= DONE;
        DONE: begin
          r_ic    <= '0;
          r_rc    <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  riscv_core_vec_lane_buf #(
    .VLMAX  (VLMAX),
    .LANE_W (LANE_W),
    .IDX_W  (IDX_W)
  ) u_lane_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_resp_take),
    .i_wr_idx  (r_rc[IDX_W-1:0]),
    .i_wr_data (memresp_data),
    .i_clr     (r_state == DONE),
    .i_n       (r_n),
    .o_data    (w_lanes)
  );

endmodule

// File: tb/tb_riscv_core_vec_load_unit.sv
`timescale 1ns/1ps
// tb_riscv_core_vec_load_unit: scoreboard bench; the stimulus pushes expected
// requests/writes, a negedge monitor pops and compares them.
module tb_riscv_core_vec_load_unit;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_val = 1'b0;
  logic         cmd_rdy;
  logic [4:0]   cmd_vd = '0;
  logic [31:0]  cmd_base = '0;
  logic [31:0]  cmd_stride = '0;
  logic [3:0]   vl = '0;
  logic         memreq_val;
  logic         memreq_rdy = 1'b1;
  logic [31:0]  memreq_addr;
  logic         memresp_val;
  logic [31:0]  memresp_data;
  logic         wen_p;
  logic [4:0]   waddr_p;
  logic [255:0] wdata_p;
  logic         busy;

  always #5 clk = ~clk;

  riscv_core_vec_load_unit #(
    .VLMAX  (8),
    .LANE_W (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_val      (cmd_val),
    .cmd_rdy      (cmd_rdy),
    .cmd_vd       (cmd_vd),
    .cmd_base     (cmd_base),
    .cmd_stride   (cmd_stride),
    .vl           (vl),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memreq_addr  (memreq_addr),
    .memresp_val  (memresp_val),
    .memresp_data (memresp_data),
    .wen_p        (wen_p),
    .waddr_p      (waddr_p),
    .wdata_p      (wdata_p),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int req_seen = 0;
  int wen_seen = 0;

  typedef struct { logic [4:0] a; logic [255:0] d; } wr_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  logic [31:0] exp_req_q [$];
  wr_t         exp_wr_q  [$];
  pend_t       pend_q    [$];

  // Memory model: ideal = same-cycle response with word = address;
  // otherwise responses come 2 cycles after their request.
  bit          ideal = 1'b1;
  bit          toggle = 1'b0;
  logic        d_val = 1'b0;
  logic [31:0] d_data = '0;
  int          cyc = 0;

  assign memresp_val  = ideal ? (memreq_val && memreq_rdy) : d_val;
  assign memresp_data = ideal ? memreq_addr : d_data;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [255:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h, required none", nm, act);
  endtask

  initial begin : mem_model
    forever begin
      @(negedge clk);
      if (!ideal && reset_n && memreq_val && memreq_rdy)
        pend_q.push_back('{memreq_addr, cyc + 2});
      @(posedge clk);
      #2;
      cyc++;
      memreq_rdy = toggle ? ~memreq_rdy : 1'b1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        d_val  = 1'b1;
        d_data = pend_q[0].addr;
        void'(pend_q.pop_front());
      end else begin
        d_val  = 1'b0;
        d_data = '0;
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  wr_t         mon_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_val_hold", 256'(memreq_val), 256'(1));
          chk("stall_addr_hold", 256'(memreq_addr), 256'(prev_addr));
        end
        if (memreq_val && memreq_rdy) begin
          req_seen++;
          if (exp_req_q.size() == 0) fail("unexpected_req", 256'(memreq_addr));
          else chk("req_addr", 256'(memreq_addr), 256'(exp_req_q.pop_front()));
        end
        prev_stall = memreq_val && !memreq_rdy;
        prev_addr  = memreq_addr;
        if (wen_p) begin
          wen_seen++;
          if (exp_wr_q.size() == 0) fail("unexpected_wen", 256'(waddr_p));
          else begin
            mon_e = exp_wr_q.pop_front();
            chk("waddr", 256'(waddr_p), 256'(mon_e.a));
            chk("wdata", wdata_p, mon_e.d);
          end
        end
      end
    end
  end

  task automatic issue(input logic [4:0] vd, input logic [31:0] base,
                       input logic [31:0] stride, input logic [3:0] vlen);
    int n;
    logic [31:0]  s;
    logic [31:0]  a;
    logic [255:0] d;
    n = (vlen > 4'd8) ? 8 : int'(vlen);
`ifdef VECLD_STRIDE_EN
    s = stride;
`else
    s = 32'd4;
`endif
    d = '0;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(i) * s;
      exp_req_q.push_back(a);
      d[i*32 +: 32] = a;
    end
    if (n > 0) exp_wr_q.push_back('{vd, d});
    cmd_vd = vd; cmd_base = base; cmd_stride = stride; vl = vlen; cmd_val = 1'b1;
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
  endtask

  // Called at T+1 (+1ns); returns the cycle offset where cmd_rdy is seen again.
  task automatic wait_ready(input string nm, input int exp_lat, input bit check_lat);
    int k;
    k = 1;
    while (!cmd_rdy && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!cmd_rdy) fail({nm, "_timeout"}, 256'(k));
    else if (check_lat) chk(nm, 256'(k), 256'(exp_lat));
  endtask

  task automatic drain(input string nm);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_req_left"}, 256'(exp_req_q.size()), 256'(0));
    chk({nm, "_wr_left"}, 256'(exp_wr_q.size()), 256'(0));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_cmd_rdy"}, 256'(cmd_rdy), 256'(1));
    chk({nm, "_busy"}, 256'(busy), 256'(0));
    chk({nm, "_memreq_val"}, 256'(memreq_val), 256'(0));
    chk({nm, "_memreq_addr"}, 256'(memreq_addr), 256'(0));
    chk({nm, "_wen_p"}, 256'(wen_p), 256'(0));
    chk({nm, "_waddr_p"}, 256'(waddr_p), 256'(0));
    chk({nm, "_wdata_p"}, wdata_p, 256'(0));
  endtask

  int r0;
  int w0;

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // vl=8, ideal memory, base 0x1000, vd=3
    r0 = req_seen;
    issue(5'd3, 32'h1000, 32'h0, 4'd8);
    chk("first_req_T+1", 256'(memreq_val), 256'(1));
    wait_ready("lat_vl8", 11, 1'b1);
    chk("reqs_vl8", 256'(req_seen - r0), 256'(8));
    drain("vl8");

    // vl=3, toggling ready, 2-cycle response delay, vl changed after accept
    ideal = 1'b0; toggle = 1'b1;
    r0 = req_seen;
    issue(5'd5, 32'h2000, 32'h0, 4'd3);
    vl = 4'd8;
    wait_ready("lat_vl3", 0, 1'b0);
    chk("reqs_vl3", 256'(req_seen - r0), 256'(3));
    toggle = 1'b0; ideal = 1'b1;
    drain("vl3");

    // vl=0: no requests, no write, ready two cycles after accept
    r0 = req_seen; w0 = wen_seen;
    issue(5'd9, 32'h3000, 32'h0, 4'd0);
    wait_ready("lat_vl0", 2, 1'b1);
    chk("reqs_vl0", 256'(req_seen - r0), 256'(0));
    chk("wens_vl0", 256'(wen_seen - w0), 256'(0));
    drain("vl0");

    // vl=15 clamps to 8
    r0 = req_seen;
    issue(5'd31, 32'h3000, 32'h0, 4'd15);
    wait_ready("lat_vl15", 11, 1'b1);
    chk("reqs_vl15", 256'(req_seen - r0), 256'(8));
    drain("vl15");

    // negative stride (unit stride expected when the option is off)
    issue(5'd12, 32'h10, 32'hFFFF_FFF8, 4'd4);
    wait_ready("lat_stride", 7, 1'b1);
    drain("stride");

    // reset during the 4th request of a vl=8 load
    ideal = 1'b0;
    issue(5'd7, 32'h5000, 32'h0, 4'd8);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst4_req_val", 256'(memreq_val), 256'(1));
    chk("rst4_req_addr", 256'(memreq_addr), 256'(32'h500C));
    w0 = wen_seen;
    reset_n = 1'b0;
    exp_req_q.delete();
    exp_wr_q.delete();
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_wen", 256'(wen_seen - w0), 256'(0));
    chk("midrst_pend_empty", 256'(pend_q.size()), 256'(0));
    ideal = 1'b1;

    // fresh command after reset, vd=0 still pulses the write
    issue(5'd0, 32'h4000, 32'h0, 4'd2);
    wait_ready("lat_post_rst", 5, 1'b1);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
